// File: rtl/register_file_pkg.sv
// Shared constants for the 32x64 register file.
// Holds PPP/WW codes and width parameters.
package register_file_pkg;

    localparam int DATA_W    = 64;
    localparam int ADDR_W    = 5;
    localparam int NUM_REGS  = 32;
    localparam int NUM_BYTES = DATA_W / 8;

    localparam logic [0:2] PPP_ALL   = 3'b000;
    localparam logic [0:2] PPP_UPPER = 3'b001;
    localparam logic [0:2] PPP_LOWER = 3'b010;
    localparam logic [0:2] PPP_EVEN  = 3'b011;
    localparam logic [0:2] PPP_ODD   = 3'b100;

    localparam logic [0:1] WW_B = 2'b00;
    localparam logic [0:1] WW_H = 2'b01;
    localparam logic [0:1] WW_W = 2'b10;
    localparam logic [0:1] WW_D = 2'b11;

endpackage

// File: rtl/rf_byte_mask.sv
// Decodes write participation (PPP) and element width (WW)
// into a big-endian byte-enable mask, be[0] covering bits 0..7.
module rf_byte_mask
    import register_file_pkg::*;
(
    input  logic [0:2] PPP,
    input  logic [0:1] WW,
    output logic [0:7] be
);

    logic [0:7] even_be;
    logic [0:7] odd_be;

    always_comb begin
        even_be = 8'h00;
        odd_be  = 8'h00;
        case (WW)
            WW_B: begin even_be = 8'b10101010; odd_be = 8'b01010101; end
            WW_H: begin even_be = 8'b11001100; odd_be = 8'b00110011; end
            WW_W: begin even_be = 8'b11110000; odd_be = 8'b00001111; end
            WW_D: begin even_be = 8'b11111111; odd_be = 8'b00000000; end
            default: begin even_be = 8'h00; odd_be = 8'h00; end
        endcase
    end

    // Codes 101..111 fall through to an empty mask.
    always_comb begin
        be = 8'h00;
        case (PPP)
            PPP_ALL:   be = 8'b11111111;
            PPP_UPPER: be = 8'b11110000;
            PPP_LOWER: be = 8'b00001111;
            PPP_EVEN:  be = even_be;
            PPP_ODD:   be = odd_be;
            default:   be = 8'h00;
        endcase
    end

endmodule

// File: rtl/register_file.sv
// 32 x 64-bit flop-based register file, two combinational read
// ports with write-through bypass and byte-masked writes.
module register_file
    import register_file_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [0:ADDR_W-1] rA_addr,
    input  logic [0:ADDR_W-1] rB_addr,
    output logic [0:DATA_W-1] rA_64bit_val,
    output logic [0:DATA_W-1] rB_64bit_val,
    input  logic              wr_en,
    input  logic [0:ADDR_W-1] wr_addr,
    input  logic [0:DATA_W-1] wr_data,
    input  logic [0:2]        PPP,
    input  logic [0:1]        WW
);

    logic [0:NUM_BYTES-1] be;
    logic [0:DATA_W-1]    regs_q [NUM_REGS];
    logic [0:DATA_W-1]    regs_d [NUM_REGS];
    logic                 wr_ok_q;
    logic                 wr_ok_d;
    logic                 wr_act;
    logic [0:DATA_W-1]    merged;

    rf_byte_mask u_mask (
        .PPP (PPP),
        .WW  (WW),
        .be  (be)
    );

    // wr_ok_q stays low for the first edge after reset release,
    // so a write coinciding with deassertion is dropped.
    always_comb begin
        wr_ok_d = 1'b1;
        wr_act  = wr_en && wr_ok_q && (wr_addr != '0);
        merged  = regs_q[wr_addr];
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (be[k]) begin
                merged[8*k +: 8] = wr_data[8*k +: 8];
            end
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (wr_act) begin
            regs_d[wr_addr] = merged;
        end
    end

    always_comb begin
        rA_64bit_val = '0;
        if (rst_n && (rA_addr != '0)) begin
            if (wr_act && (rA_addr == wr_addr)) begin
                rA_64bit_val = merged;
            end else begin
                rA_64bit_val = regs_q[rA_addr];
            end
        end
    end

    always_comb begin
        rB_64bit_val = '0;
        if (rst_n && (rB_addr != '0)) begin
            if (wr_act && (rB_addr == wr_addr)) begin
                rB_64bit_val = merged;
            end else begin
                rB_64bit_val = regs_q[rB_addr];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_ok_q <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            wr_ok_q <= wr_ok_d;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
// Inputs change 1ns after posedge; outputs sampled before next posedge.
module tb_register_file;

    logic        clk;
    logic        rst_n;
    logic [0:4]  rA_addr;
    logic [0:4]  rB_addr;
    logic [0:63] rA_64bit_val;
    logic [0:63] rB_64bit_val;
    logic        wr_en;
    logic [0:4]  wr_addr;
    logic [0:63] wr_data;
    logic [0:2]  PPP;
    logic [0:1]  WW;

    int tests;
    int fails;

    register_file dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rA_addr      (rA_addr),
        .rB_addr      (rB_addr),
        .rA_64bit_val (rA_64bit_val),
        .rB_64bit_val (rB_64bit_val),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .PPP          (PPP),
        .WW           (WW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_write(input logic [0:4] a, input logic [0:63] d,
                            input logic [0:2] p, input logic [0:1] w);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        PPP     = p;
        WW      = w;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
    endtask

    task automatic idle();
        wr_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 5'd4;
        wr_data = 64'hDEAD_BEEF_0000_1111;
        PPP     = 3'b000;
        WW      = 2'b00;
        rA_addr = 5'd4;
        rB_addr = 5'd4;
        #1;
        tests++;
        if (rA_64bit_val !== 64'h0 || rB_64bit_val !== 64'h0) begin
            fails++;
            $display("FAIL reset_bypass_suppressed rA=%h rB=%h want 0",
                     rA_64bit_val, rB_64bit_val);
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        // release reset mid-cycle; the next edge's write must be dropped
        rst_n = 1'b1;
        do_write(5'd1, 64'h1111_2222_3333_4444, 3'b000, 2'b00);
        rA_addr = 5'd1;
        rB_addr = 5'd4;
        #1;
        tests++;
        if (rA_64bit_val !== 64'h0 || rB_64bit_val !== 64'h0) begin
            fails++;
            $display("FAIL first_edge_write rA=%h rB=%h want 0",
                     rA_64bit_val, rB_64bit_val);
        end
        for (int i = 0; i < 32; i++) begin
            rA_addr = i[4:0];
            rB_addr = 5'(31 - i);
            #1;
            tests++;
            if (rA_64bit_val !== 64'h0 || rB_64bit_val !== 64'h0) begin
                fails++;
                $display("FAIL reset_read_%0d rA=%h rB=%h want 0",
                         i, rA_64bit_val, rB_64bit_val);
            end
        end
    endtask

    task automatic test_full_write();
        do_write(5'd5, 64'h0123456789ABCDEF, 3'b000, 2'b10);
        rA_addr = 5'd5;
        rB_addr = 5'd5;
        #1;
        tests++;
        if (rA_64bit_val !== 64'h0123456789ABCDEF ||
            rB_64bit_val !== 64'h0123456789ABCDEF) begin
            fails++;
            $display("FAIL full_write rA=%h rB=%h want 0123456789abcdef",
                     rA_64bit_val, rB_64bit_val);
        end
    endtask

    task automatic test_masks();
        do_write(5'd5, 64'hFFFFFFFFFFFFFFFF, 3'b011, 2'b00);
        rA_addr = 5'd5;
        #1;
        tests++;
        if (rA_64bit_val !== 64'hFF23FF67FFABFFEF) begin
            fails++;
            $display("FAIL even_byte got=%h want ff23ff67ffabffef", rA_64bit_val);
        end
        do_write(5'd5, 64'h0, 3'b010, 2'b11);
        #1;
        tests++;
        if (rA_64bit_val !== 64'hFF23FF6700000000) begin
            fails++;
            $display("FAIL lower_half got=%h want ff23ff6700000000", rA_64bit_val);
        end
        // consecutive edges to R10, each mask applied on the previous result
        rA_addr = 5'd10;
        do_write(5'd10, 64'hFFFFFFFFFFFFFFFF, 3'b000, 2'b00);
        do_write(5'd10, 64'h0, 3'b100, 2'b00);
        #1;
        tests++;
        if (rA_64bit_val !== 64'hFF00FF00FF00FF00) begin
            fails++;
            $display("FAIL odd_byte got=%h want ff00ff00ff00ff00", rA_64bit_val);
        end
        do_write(5'd10, 64'hFFFFFFFFFFFFFFFF, 3'b000, 2'b00);
        do_write(5'd10, 64'h0, 3'b100, 2'b01);
        #1;
        tests++;
        if (rA_64bit_val !== 64'hFFFF0000FFFF0000) begin
            fails++;
            $display("FAIL odd_half got=%h want ffff0000ffff0000", rA_64bit_val);
        end
        do_write(5'd10, 64'h0, 3'b011, 2'b10);
        #1;
        tests++;
        if (rA_64bit_val !== 64'h00000000FFFF0000) begin
            fails++;
            $display("FAIL even_word got=%h want 00000000ffff0000", rA_64bit_val);
        end
        do_write(5'd10, 64'h1234567800000000, 3'b001, 2'b01);
        #1;
        tests++;
        if (rA_64bit_val !== 64'h12345678FFFF0000) begin
            fails++;
            $display("FAIL upper_half got=%h want 12345678ffff0000", rA_64bit_val);
        end
        do_write(5'd10, 64'hAAAAAAAAAAAAAAAA, 3'b011, 2'b11);
        #1;
        tests++;
        if (rA_64bit_val !== 64'hAAAAAAAAAAAAAAAA) begin
            fails++;
            $display("FAIL even_dword got=%h want aaaaaaaaaaaaaaaa", rA_64bit_val);
        end
    endtask

    task automatic test_bypass();
        wr_en   = 1'b1;
        wr_addr = 5'd7;
        wr_data = 64'hA5A5A5A5A5A5A5A5;
        PPP     = 3'b000;
        WW      = 2'b00;
        rA_addr = 5'd7;
        rB_addr = 5'd7;
        #1;
        tests++;
        if (rA_64bit_val !== 64'hA5A5A5A5A5A5A5A5 ||
            rB_64bit_val !== 64'hA5A5A5A5A5A5A5A5) begin
            fails++;
            $display("FAIL bypass_full rA=%h rB=%h want a5a5a5a5a5a5a5a5",
                     rA_64bit_val, rB_64bit_val);
        end
        @(posedge clk);
        #1;
        // merged bypass: odd halves from wr_data, rest from storage
        wr_data = 64'h0;
        PPP     = 3'b100;
        WW      = 2'b01;
        rB_addr = 5'd5;
        #1;
        tests++;
        if (rA_64bit_val !== 64'hA5A50000A5A50000 ||
            rB_64bit_val !== 64'hFF23FF6700000000) begin
            fails++;
            $display("FAIL bypass_merge rA=%h rB=%h want a5a50000a5a50000/ff23ff6700000000",
                     rA_64bit_val, rB_64bit_val);
        end
        @(posedge clk);
        #1;
        wr_addr = 5'd0;
        wr_data = 64'h1;
        PPP     = 3'b000;
        rA_addr = 5'd0;
        rB_addr = 5'd7;
        #1;
        tests++;
        if (rA_64bit_val !== 64'h0 || rB_64bit_val !== 64'hA5A50000A5A50000) begin
            fails++;
            $display("FAIL r0_bypass rA=%h rB=%h want 0/a5a50000a5a50000",
                     rA_64bit_val, rB_64bit_val);
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        #1;
        tests++;
        if (rA_64bit_val !== 64'h0) begin
            fails++;
            $display("FAIL r0_write got=%h want 0", rA_64bit_val);
        end
    endtask

    task automatic test_noop();
        do_write(5'd9, 64'h1122334455667788, 3'b000, 2'b00);
        do_write(5'd9, 64'h0, 3'b101, 2'b00);
        rA_addr = 5'd9;
        rB_addr = 5'd9;
        #1;
        tests++;
        if (rA_64bit_val !== 64'h1122334455667788) begin
            fails++;
            $display("FAIL ppp101_noop got=%h want 1122334455667788", rA_64bit_val);
        end
        do_write(5'd9, 64'h0, 3'b100, 2'b11);
        #1;
        tests++;
        if (rB_64bit_val !== 64'h1122334455667788) begin
            fails++;
            $display("FAIL odd_dword_noop got=%h want 1122334455667788", rB_64bit_val);
        end
        do_write(5'd9, 64'h0, 3'b111, 2'b10);
        #1;
        tests++;
        if (rA_64bit_val !== 64'h1122334455667788) begin
            fails++;
            $display("FAIL ppp111_noop got=%h want 1122334455667788", rA_64bit_val);
        end
    endtask

    task automatic test_async_reset_alu();
        logic [0:63] alu;
        rA_addr = 5'd5;
        rB_addr = 5'd9;
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if (rA_64bit_val !== 64'h0 || rB_64bit_val !== 64'h0) begin
            fails++;
            $display("FAIL async_clear rA=%h rB=%h want 0",
                     rA_64bit_val, rB_64bit_val);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        do_write(5'd3, 64'd15, 3'b000, 2'b00);
        do_write(5'd5, 64'd14, 3'b000, 2'b00);
        rA_addr = 5'd3;
        rB_addr = 5'd5;
        #1;
        alu = rA_64bit_val & rB_64bit_val;
        tests++;
        if (alu !== 64'd14) begin
            fails++;
            $display("FAIL alu_vand got=%0d want 14", alu);
        end
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        PPP     = '0;
        WW      = '0;
        rA_addr = '0;
        rB_addr = '0;
        test_reset();
        test_full_write();
        test_masks();
        test_bypass();
        test_noop();
        test_async_reset_alu();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The module SHALL have the following ports; all buses SHALL be big-endian, with bit 0 as the MSB:
- clk  input  1  rising-edge clock; the block's only clock.
- rst_n  input  1  reset, asynchronous, active-low.
- rA_addr  input  [0:4]  read-port A register index.
- rB_addr  input  [0:4]  read-port B register index.
- rA_64bit_val  output  [0:63]  read-port A data, which feeds the ALU rA operand.
- rB_64bit_val  output  [0:63]  read-port B data, which feeds the ALU rB operand.
- wr_en  input  1  write strobe from writeback.
- wr_addr  input  [0:4]  write register index.
- wr_data  input  [0:63]  write data, which carries the ALU result.
- PPP  input  [0:2]  write participation field.
- WW  input  [0:1]  element width: 00 = 8, 01 = 16, 10 = 32, 11 = 64 bits.

Function
REQ-002 The block SHALL hold 32 registers of 64 bits each, R0..R31.
REQ-003 Reads of R0 SHALL return 64'h0, and writes to R0 SHALL be discarded.
REQ-004 Both read ports SHALL be combinational from the address and storage, with zero-cycle latency.
REQ-005 A write SHALL occur on the rising clk edge when wr_en=1 and SHALL update only the bytes enabled by byte-mask be[0:7], where be[k] covers bits 8k..8k+7.
REQ-006 be SHALL be decoded from PPP and WW as follows:
- 000: all 8 bytes.
- 001: bytes 0-3 (bits 0:31).
- 010: bytes 4-7 (bits 32:63).
- 011: even-indexed elements of width WW, with element 0 at bits 0..w-1.
- 100: odd-indexed elements of width WW.
- 101/110/111: no bytes; the write is a no-op.
REQ-007 For even/odd participation, WW=00 SHALL give be=10101010 (even) or 01010101 (odd).
REQ-008 For even/odd participation, WW=01 SHALL give be=11001100 (even) or 00110011 (odd).
REQ-009 For even/odd participation, WW=10 SHALL give be=11110000 (even) or 00001111 (odd).
REQ-010 For even/odd participation, WW=11 SHALL give be=11111111 (even) or 00000000 (odd).
REQ-011 WW SHALL be ignored for PPP codes 000, 001, 010 and 101-111.
REQ-012 Write-through bypass: when wr_en=1 and a read address equals wr_addr (non-zero) in the same cycle, that read port SHALL return the merged value, i.e. enabled bytes from wr_data and remaining bytes from storage.
REQ-013 Both read ports addressing the same register SHALL return identical data, including under bypass.
REQ-014 The block SHALL add no pipeline stage and no stall/handshake: a write accepted on edge N SHALL be visible from storage for reads in cycle N+1.
REQ-015 Back-to-back writes to the same register on consecutive edges SHALL each apply their own mask onto the result of the previous write.

Reset
REQ-016 Assertion of rst_n=0 SHALL clear all 32 registers to 64'h0 immediately, without waiting for a clk edge.
REQ-017 While rst_n=0, both read outputs SHALL be 64'h0, and writes and bypass SHALL be suppressed.
REQ-018 A write presented on the same edge on which rst_n deasserts SHALL be discarded; the first accepted write SHALL be on the following edge.
REQ-019 Reset asserted mid-sequence SHALL discard any write not already committed.

Structure
REQ-020 A shared package SHALL hold:
- PPP code constants: PPP_ALL, PPP_UPPER, PPP_LOWER, PPP_EVEN, PPP_ODD.
- WW code constants: WW_B, WW_H, WW_W, WW_D.
- Width constants: DATA_W=64, ADDR_W=5, NUM_REGS=32.
REQ-021 The PPP/WW-to-byte-mask decode SHALL be a separate combinational sub-module, rf_byte_mask (inputs PPP and WW, output be[0:7]), shared by the write path and the bypass path.
REQ-022 The storage SHALL be flip-flops, not an inferred RAM macro, so that the asynchronous clear of REQ-016 holds.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Reset, then read R0..R31 on both ports -> all reads 64'h0.
- Write R5=64'h0123456789ABCDEF with PPP=000; next cycle read rA=5, rB=5 -> both return 64'h0123456789ABCDEF.
- With R5 as above, write 64'hFFFFFFFFFFFFFFFF with PPP=011, WW=00 -> R5 = 64'hFF23FF67FFABFFEF; then PPP=010 with wr_data=0 -> R5 = 64'hFF23FF6700000000.
- Same-cycle write R7=64'hA5A5A5A5A5A5A5A5 (PPP=000) with rA_addr=7 -> rA_64bit_val = 64'hA5A5A5A5A5A5A5A5 in that cycle (bypass); write R0=64'h1 -> R0 still reads 0, with no bypass.
- PPP=101 write to R9 -> R9 unchanged; PPP=100, WW=11 write -> R9 unchanged.
- Assert rst_n mid-cycle with R5 non-zero -> R5 reads 0 before the next clk edge; drive R5 from the register file into the ALU (R_ins=000001 VAND, R3=15, R5=14) -> ALU output 14.
